// File: rtl/chunked_addsub_unit.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with the ripple carry registered between chunks. Start/busy/done handshake.
module chunked_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             co_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             c_into_msb;
    logic             last_chunk;

    // Current chunk ripple stage
    always_comb begin
        base       = 32'(cnt_q) * CHUNK;
        a_ch       = opa_q[base +: CHUNK];
        b_ch       = opb_q[base +: CHUNK];
        ch_sum     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk's top bit recovered from its sum and operand bits
        c_into_msb = ch_sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
        last_chunk = (cnt_q == LastCnt);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    opa_d   = a_i;
                    opb_d   = sub_i ? ~b_i : b_i;
                    carry_d = ci_i ^ sub_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d[base +: CHUNK] = ch_sum[CHUNK-1:0];
                carry_d              = ch_sum[CHUNK];
                if (last_chunk) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    result_d = acc_d;
                    co_d     = ch_sum[CHUNK];
                    ovf_d    = c_into_msb ^ ch_sum[CHUNK];
                    zero_d   = (acc_d == '0);
                    neg_d    = acc_d[WIDTH-1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign co_o     = co_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = zero_q;
    assign neg_o    = neg_q;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Self-checking bench for chunked_addsub_unit: directed table, randomized ops against
// an arithmetic reference, held-start, mid-run reset and 8-bit degenerate chunkings.
module tb_chunked_addsub_unit;

    localparam int N = 4;      // 16 / 4
    localparam int P = N + 2;  // RUN cycles + DONE + IDLE between accepts

    logic        clk;
    logic        rst_n;
    logic        start_i, sub_i, ci_i;
    logic [15:0] a_i, b_i;
    logic        busy_o, done_o, co_o, ovf_o, zero_o, neg_o;
    logic [15:0] result_o;

    logic        start8, sub8, ci8;
    logic [7:0]  a8, b8;
    logic        busy_c8, done_c8, co_c8, ovf_c8, zero_c8, neg_c8;
    logic [7:0]  res_c8;
    logic        busy_c1, done_c1, co_c1, ovf_c1, zero_c1, neg_c1;
    logic [7:0]  res_c1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_res;

    chunked_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .sub_i(sub_i), .a_i(a_i), .b_i(b_i),
        .ci_i(ci_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .co_o(co_o),
        .ovf_o(ovf_o), .zero_o(zero_o), .neg_o(neg_o)
    );

    chunked_addsub_unit #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .ci_i(ci8), .busy_o(busy_c8), .done_o(done_c8), .result_o(res_c8), .co_o(co_c8),
        .ovf_o(ovf_c8), .zero_o(zero_c8), .neg_o(neg_c8)
    );

    chunked_addsub_unit #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .ci_i(ci8), .busy_o(busy_c1), .done_o(done_c1), .result_o(res_c1), .co_o(co_c1),
        .ovf_o(ovf_c1), .zero_o(zero_c1), .neg_o(neg_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] res;
        logic        co;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // {result, co, ovf, zero, neg} from plain WIDTH+1-bit arithmetic
    function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic civ, input logic subv);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] r;
        logic        ov;
        bb   = subv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + 17'(civ ^ subv);
        r    = full[15:0];
        ov   = (av[15] == bb[15]) && (r[15] != av[15]);
        return {r, full[16], ov, (r == 16'h0), r[15]};
    endfunction

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                         input logic subv, output logic [19:0] got);
        int lat;
        int wait_cnt;
        bit held_ok;
        bit hs_ok;
        @(negedge clk);
        a_i = av; b_i = bv; ci_i = civ; sub_i = subv; start_i = 1'b1;
        wait_cnt = 0;
        do begin
            @(posedge clk); #1;
            wait_cnt++;
        end while (!busy_o && wait_cnt < 5);
        check("accept", {31'd0, busy_o}, 32'd1);
        start_i = 1'b0;
        // Changing inputs after acceptance must not affect the operation
        a_i = ~av; b_i = ~bv; ci_i = ~civ; sub_i = ~subv;
        lat = 0; held_ok = 1'b1; hs_ok = 1'b1;
        while (!done_o && lat < 40) begin
            if (result_o !== last_res) held_ok = 1'b0;
            if (!busy_o) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (busy_o && done_o) hs_ok = 1'b0;
        end
        check("latency", lat, N);
        check("result_held", {31'd0, held_ok}, 32'd1);
        check("handshake", {31'd0, hs_ok}, 32'd1);
        got = {result_o, co_o, ovf_o, zero_o, neg_o};
    endtask

    initial begin
        logic [19:0] got;
        logic [19:0] exp;
        logic [15:0] ra, rb;
        logic        rci, rsub;
        logic [15:0] va[3*P];
        logic [15:0] vb[3*P];
        int          lat_a, lat_b;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; start_i = 1'b0; sub_i = 1'b0; ci_i = 1'b0; a_i = '0; b_i = '0;
        start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = '0; b8 = '0;
        last_res = '0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", {16'd0, result_o}, 32'd0);
        check("rst_flags", {28'd0, co_o, ovf_o, zero_o, neg_o}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, got);
            check($sformatf("vec%0d_result", i), {16'd0, got[19:4]}, {16'd0, vecs[i].res});
            check($sformatf("vec%0d_co", i), {31'd0, got[3]}, {31'd0, vecs[i].co});
            check($sformatf("vec%0d_ovf", i), {31'd0, got[2]}, {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_zero", i), {31'd0, got[1]}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d_neg", i), {31'd0, got[0]}, {31'd0, vecs[i].neg});
            last_res = vecs[i].res;
        end

        // Randomized against reference
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rci = 1'($urandom); rsub = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            exp = model(ra, rb, rci, rsub);
            do_op(ra, rb, rci, rsub, got);
            check($sformatf("rand%0d", i), {12'd0, got}, {12'd0, exp});
            last_res = exp[19:4];
        end

        // start held high with operands changing every cycle
        @(negedge clk); @(negedge clk); @(negedge clk);
        for (int c = 0; c < 3 * P; c++) begin
            @(negedge clk);
            va[c] = 16'($urandom); vb[c] = 16'($urandom);
            a_i = va[c]; b_i = vb[c]; ci_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
            @(posedge clk); #1;
            if (c % P == N) begin
                exp = model(va[c-N], vb[c-N], 1'b0, 1'b0);
                check($sformatf("hold_done%0d", c), {31'd0, done_o}, 32'd1);
                check($sformatf("hold_res%0d", c), {12'd0, result_o, co_o, ovf_o, zero_o,
                      neg_o}, {12'd0, exp});
                last_res = exp[19:4];
            end else begin
                check($sformatf("hold_nodone%0d", c), {31'd0, done_o}, 32'd0);
                check($sformatf("hold_stable%0d", c), {16'd0, result_o}, {16'd0, last_res});
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk); @(negedge clk);

        // Non-zero result beforehand so the reset clear is observable
        do_op(16'h0F0F, 16'h8001, 1'b0, 1'b0, got);
        check("pre_reset", {16'd0, got[19:4]}, 32'h8F10);
        @(negedge clk);
        a_i = 16'hFFFF; b_i = 16'hFFFF; ci_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        if (done_o) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrun_busy", {31'd0, busy_o}, 32'd0);
        check("midrun_done", {31'd0, done_o}, 32'd0);
        check("midrun_result", {16'd0, result_o}, 32'd0);
        check("midrun_flags", {28'd0, co_o, ovf_o, zero_o, neg_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, got);
        check("post_reset", {12'd0, got}, {12'd0, 16'h0002, 4'b0000});

        // Degenerate chunkings at WIDTH=8
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat_a = -1; lat_b = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_c8 && lat_a < 0) lat_a = c;
            if (done_c1 && lat_b < 0) lat_b = c;
            if (lat_a >= 0 && lat_b >= 0) break;
        end
        check("c8_latency", lat_a, 1);
        check("c1_latency", lat_b, 8);
        check("c8_out", {19'd0, res_c8, co_c8, ovf_c8, zero_c8, neg_c8}, {19'd0, 13'b0000_0000_1010});
        check("c1_out", {19'd0, res_c1, co_c1, ovf_c1, zero_c1, neg_c1}, {19'd0, 13'b0000_0000_1010});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
